ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 4, RAM address width.
REQ-002 SHALL have parameter DW, default 8, RAM data and bus width.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  access request from requester 0/1.
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read, qualified by reqN.
REQ-007 SHALL have ports addr0/addr1  input  AW  target RAM address.
REQ-008 SHALL have ports wdata0/wdata1  input  DW  write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: request accepted and latched.
REQ-010 SHALL have ports done0/done1  output  1  one-cycle pulse: access complete.
REQ-011 SHALL have port rdata  output  DW  data from the last completed read; shared by both requesters.
REQ-012 SHALL have port ram_addr  output  AW  RAM address.
REQ-013 SHALL have ports ram_cs/ram_oa/ram_wa  output  1  RAM chip select, output enable, write enable.
REQ-014 SHALL have port bus_out  output  DW  data to drive onto the shared bus.
REQ-015 SHALL have port bus_oe  output  1  enables the top-level tristate driver of bus_out.
REQ-016 SHALL have port bus_in  input  DW  sampled value of the shared bus.

Function
REQ-017 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE, one cycle each in SETUP and ACCESS.
REQ-018 In IDLE with any req high, SHALL select a winner, latch its we/addr/wdata, pulse its gnt for that cycle, and go to SETUP; with no req it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: a single requester always wins; on a tie the port other than last-served wins; last-served updates on grant.
REQ-020 In SETUP: ram_cs=1, ram_addr=latched addr, ram_oa=0, ram_wa=0, bus_oe=latched we, bus_out=latched wdata.
REQ-021 In ACCESS: ram_cs=1, ram_addr held, ram_wa=we, ram_oa=~we, bus_oe=we; a write commits at the rising edge ending ACCESS.
REQ-022 On a read, rdata SHALL capture bus_in at the rising edge ending ACCESS; rdata SHALL be unchanged by writes.
REQ-023 doneN SHALL pulse high for exactly the cycle after ACCESS (FSM back in IDLE); a new grant MAY occur in that same cycle (back-to-back, 3 cycles per access).
REQ-024 In IDLE: ram_cs, ram_oa, ram_wa and bus_oe SHALL be 0; ram_addr and bus_out SHALL hold their last values.
REQ-025 bus_oe and ram_oa SHALL never be high in the same cycle.
REQ-026 Requests SHALL be sampled only in IDLE; req changes after gnt SHALL have no effect on the transaction in flight.
REQ-027 A req deasserted before being granted SHALL be dropped with no gnt or done.
REQ-028 At most one gnt and one done SHALL be high in any cycle.

Reset
REQ-029 rst SHALL immediately force state=IDLE; gnt0/1, done0/1, ram_cs, ram_oa, ram_wa and bus_oe = 0; ram_addr, bus_out and rdata = 0; last-served = port 1, so port 0 wins the first tie.
REQ-030 rst asserted mid-transaction SHALL abort it: no write commit after rst rises, no done pulse, and no gnt until the first IDLE cycle after release.

Structure
REQ-031 Shared package ram_arb_pkg SHALL hold the FSM state enum (IDLE, SETUP, ACCESS) and default AW/DW constants.
REQ-032 Winner selection SHALL be a sub-module rr_arb2 (inputs req0, req1, last; output winner); the FSM, latches and RAM drive SHALL stay in ram_arbiter.

Verification
REQ-033 Write: req0=1, we0=1, addr0=4'h3, wdata0=8'hA5 in IDLE -> gnt0 at cycle 0; cs=1 and bus_oe=1 at cycles 1-2; wa=1 at cycle 2 only; done0 at cycle 3.
REQ-034 Read-back: after REQ-033, req1=1, we1=0, addr1=4'h3 -> ram_oa=1 at ACCESS, bus_oe=0 throughout, rdata=8'hA5 with done1.
REQ-035 Tie from reset: req0=req1=1 held -> grants alternate 0,1,0,1, one every 3 cycles; no gnt/done overlap.
REQ-036 Sweep: port 0 writes addr 0..7 with data 8'h00..8'h07, then reads addr 0..7 -> rdata equals 8'h00..8'h07 in order, each read exactly 3 cycles apart.
REQ-037 Reset mid-op: rst asserted during ACCESS of a write to 4'h5 with 8'hFF -> all RAM controls 0 immediately, no done, later read of 4'h5 returns prior contents.
REQ-038 Late drop: req1 pulsed for one cycle while port 0's transaction is in SETUP -> no gnt1 and no done1 ever.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding and default widths.
package ram_arb_pkg;

  localparam int unsigned DefaultAw = 4;
  localparam int unsigned DefaultDw = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; last = 1 means port 1 was served most recently.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  // A lone requester always wins; on a tie the port not served last wins.
  assign winner = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one external RAM with a fixed IDLE/SETUP/ACCESS sequence.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW = DefaultAw,
  parameter int unsigned DW = DefaultDw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_cs,
  output logic          ram_oa,
  output logic          ram_wa,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  input  logic [DW-1:0] bus_in
);

  state_t        state_q, state_d;
  logic          last_q;
  logic          sel_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          done0_q, done1_q;
  logic          win;
  logic          grant;

  rr_arb2 u_rr_arb2 (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .winner (win)
  );

  assign grant = (state_q == IDLE) && (req0 || req1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req0 || req1) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done0_q <= (state_q == ACCESS) && !sel_q;
      done1_q <= (state_q == ACCESS) && sel_q;
      if (grant) begin
        last_q  <= win;
        sel_q   <= win;
        we_q    <= win ? we1 : we0;
        addr_q  <= win ? addr1 : addr0;
        wdata_q <= win ? wdata1 : wdata0;
      end
      if ((state_q == ACCESS) && !we_q) rdata_q <= bus_in;
    end
  end

  assign gnt0     = grant && !win;
  assign gnt1     = grant && win;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign rdata    = rdata_q;
  assign ram_addr = addr_q;
  assign bus_out  = wdata_q;
  assign ram_cs   = (state_q == SETUP) || (state_q == ACCESS);
  // Output enable only in ACCESS of a read, so bus_oe and ram_oa never overlap.
  assign ram_oa   = (state_q == ACCESS) && !we_q;
  assign ram_wa   = (state_q == ACCESS) && we_q;
  assign bus_oe   = ram_cs && we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: external RAM, transaction-level model and directed tests.
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata, bus_out, bus_in;
  logic [AW-1:0] ram_addr;
  logic          ram_cs, ram_oa, ram_wa, bus_oe;

  int n_cmp = 0;
  int n_bad = 0;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_cs   (ram_cs),
    .ram_oa   (ram_oa),
    .ram_wa   (ram_wa),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .bus_in   (bus_in)
  );

  always #5 clk = ~clk;

  // External RAM and shared bus.
  logic [DW-1:0] mem [16] = '{default: '0};
  assign bus_in = bus_oe ? bus_out : (ram_oa ? mem[ram_addr] : '0);
  always @(posedge clk) if (ram_cs && ram_wa) mem[ram_addr] <= bus_in;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: phase counts cycles since grant (0 = no transaction).
  int            ph_m = 0;
  int            last_m = 1;
  int            port_m = 0;
  int            done_m = -1;
  bit            we_m = 0;
  logic [AW-1:0] addr_m = '0;
  logic [DW-1:0] wdata_m = '0, rdata_m = '0;
  logic [DW-1:0] shadow [16] = '{default: '0};
  int            win_m;
  bit            any_m;

  always @(negedge clk) begin
    if (rst) begin
      ph_m = 0; last_m = 1; done_m = -1; we_m = 0;
      addr_m = '0; wdata_m = '0; rdata_m = '0;
    end
    any_m = !rst && (req0 || req1);
    win_m = (req0 && req1) ? (last_m == 1 ? 0 : 1) : (req1 ? 1 : 0);
    chk("m_gnt0", gnt0, (ph_m == 0 && any_m && win_m == 0));
    chk("m_gnt1", gnt1, (ph_m == 0 && any_m && win_m == 1));
    chk("m_done0", done0, done_m == 0);
    chk("m_done1", done1, done_m == 1);
    chk("m_cs", ram_cs, ph_m != 0);
    chk("m_oa", ram_oa, ph_m == 2 && !we_m);
    chk("m_wa", ram_wa, ph_m == 2 && we_m);
    chk("m_oe", bus_oe, ph_m != 0 && we_m);
    chk("m_addr", ram_addr, addr_m);
    chk("m_bus_out", bus_out, wdata_m);
    chk("m_rdata", rdata, rdata_m);
    chk("oe_oa_excl", bus_oe && ram_oa, 0);
    if (!rst) begin
      done_m = (ph_m == 2) ? port_m : -1;
      if (ph_m == 2) begin
        if (we_m) shadow[addr_m] = wdata_m;
        else      rdata_m = shadow[addr_m];
      end
      if (ph_m == 0) begin
        if (any_m) begin
          port_m  = win_m;
          last_m  = win_m;
          we_m    = (win_m == 1) ? we1 : we0;
          addr_m  = (win_m == 1) ? addr1 : addr0;
          wdata_m = (win_m == 1) ? wdata1 : wdata0;
          ph_m    = 1;
        end
      end else begin
        ph_m = (ph_m == 2) ? 0 : ph_m + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    chk("rst_gnt", {gnt0, gnt1, done0, done1}, 4'b0);
    chk("rst_ctl", {ram_cs, ram_oa, ram_wa, bus_oe}, 4'b0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // Write A5 to address 3 from port 0.
    req0 = 1; we0 = 1; addr0 = 4'h3; wdata0 = 8'hA5;
    @(negedge clk); chk("wr_gnt0", gnt0, 1);
    cyc(); req0 = 0;
    @(negedge clk); chk("wr_setup", {ram_cs, bus_oe, ram_wa}, 3'b110);
    cyc();
    @(negedge clk); chk("wr_access", {ram_cs, bus_oe, ram_wa}, 3'b111);
    cyc();
    @(negedge clk); chk("wr_done0", {done0, ram_cs, bus_oe}, 3'b100);
    cyc();

    // Read it back from port 1.
    req1 = 1; we1 = 0; addr1 = 4'h3;
    @(negedge clk); chk("rd_gnt1", gnt1, 1);
    cyc(); req1 = 0;
    @(negedge clk); chk("rd_setup", {ram_cs, bus_oe, ram_oa}, 3'b100);
    cyc();
    @(negedge clk); chk("rd_access", {ram_cs, bus_oe, ram_oa}, 3'b101);
    cyc();
    @(negedge clk); chk("rd_done1", done1, 1); chk("rd_rdata", rdata, 8'hA5);
    cyc();

    // Tie from reset: grants alternate starting with port 0.
    do_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("tie_gnt0", gnt0, (i % 6) == 0);
      chk("tie_gnt1", gnt1, (i % 6) == 3);
      chk("tie_done0", done0, (i % 6) == 3);
      chk("tie_done1", done1, (i > 0) && ((i % 6) == 0));
      cyc();
    end
    req0 = 0; req1 = 0;

    // Sweep: back-to-back writes then reads of addresses 0..7.
    req0 = 1; we0 = 1;
    for (int i = 0; i < 8; i++) begin
      addr0 = AW'(i); wdata0 = DW'(i);
      @(negedge clk); chk("sw_wr_gnt", gnt0, 1);
      cyc(); cyc(); cyc();
    end
    we0 = 0;
    for (int i = 0; i < 8; i++) begin
      addr0 = AW'(i);
      @(negedge clk); chk("sw_rd_gnt", gnt0, 1);
      if (i > 0) begin
        chk("sw_rd_done", done0, 1);
        chk("sw_rd_data", rdata, i - 1);
      end
      cyc(); cyc(); cyc();
    end
    req0 = 0;
    @(negedge clk); chk("sw_rd_done", done0, 1); chk("sw_rd_data", rdata, 7);
    cyc();

    // Reset during ACCESS of a write aborts it.
    req0 = 1; we0 = 1; addr0 = 4'h5; wdata0 = 8'hFF;
    @(negedge clk); chk("ab_gnt0", gnt0, 1);
    cyc(); req0 = 0;
    @(negedge clk);
    cyc();
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ab_ctl", {ram_cs, ram_oa, ram_wa, bus_oe}, 4'b0);
    chk("ab_done", done0, 0);
    cyc(); rst = 1'b0;
    @(negedge clk); chk("ab_done_after", done0, 0); chk("ab_rdata", rdata, 0);
    cyc();
    req0 = 1; we0 = 0; addr0 = 4'h5;
    @(negedge clk); chk("ab_rd_gnt", gnt0, 1);
    cyc(); req0 = 0; cyc(); cyc();
    @(negedge clk); chk("ab_rd_done", done0, 1); chk("ab_rd_data", rdata, 8'h05);
    cyc();

    // Port 1 request dropped while port 0 is in SETUP is never served.
    req0 = 1; we0 = 0; addr0 = 4'h2;
    @(negedge clk); chk("ld_gnt0", gnt0, 1);
    cyc(); req0 = 0; req1 = 1; we1 = 1;
    @(negedge clk); chk("ld_gnt1_setup", gnt1, 0);
    cyc(); req1 = 0;
    @(negedge clk);
    cyc();
    @(negedge clk); chk("ld_done0", done0, 1); chk("ld_gnt1", gnt1, 0); chk("ld_done1", done1, 0);
    cyc();
    @(negedge clk); chk("ld_gnt1_late", gnt1, 0); chk("ld_done1_late", done1, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
